hash_message_build: RTL and testbench
=====================================

Name: hash_message_build

Overview:
- Producer side of the 512-bit block interface of the SHA-256 compression stage.
- Accepts a message as a stream of big-endian 32-bit words, with a byte count on the final word.
- Packs the words into 512-bit blocks and appends SHA-256 padding: 0x80, zero fill, and the 64-bit big-endian message bit length.
- Emits blocks with a last flag marking the final block of each message; data_out connects directly to the compression stage's data_in.

Parameters:
LEN_W, 64, width of the message bit-length counter.
- Values below 64 are zero-extended into the 64-bit length field.
- The counter wraps modulo 2^LEN_W.

Ports:
clk  input  1  clock
nrst  input  1  reset, asynchronous, active-low
en  input  1  enable; when 0 all registers hold and data_in_ready is forced 0
sync_rst  input  1  synchronous localised reset; same effect as nrst
data_in  input  32  message word; bits [31:24] are the first byte
data_in_bytes  input  3  valid bytes in the word, MSB-aligned; sampled only with data_in_last; legal 0..4, values >4 treated as 4
data_in_last  input  1  final word of the message
data_in_valid  input  1  input word valid
data_in_ready  output  1  input word accepted when valid && ready && en
data_out  output  512  padded block; bits [511:480] are word 0
data_out_last  output  1  final block of the message
data_out_valid  output  1  block valid
data_out_ready  input  1  downstream accepts the block

Behaviour:
- Reset (nrst low or sync_rst high): state=FILL, word_idx=0, bit_len=0, pending=0, data_out=0, data_out_valid=0, data_out_last=0, data_in_ready=0.
- Reset takes effect mid-operation; any partial block and partial message are discarded.
- All transfers and state changes are qualified by en. With en low:
  - data_out_valid and data_out hold their values.
  - data_in_ready=0.
- FILL state:
  - data_in_ready=1.
  - An accepted word is written to buffer word word_idx.
  - A non-last word adds 32 to bit_len.
  - A last word adds 8*bytes to bit_len. Its invalid low bytes are zeroed.
  - Non-last word with word_idx==15: data_out=buffer, data_out_last=0, valid=1 the next cycle, go to EMIT, word_idx=0.
  - Non-last word with word_idx<15: word_idx+1.
  - Last word: record pad position p = 4*word_idx + bytes (0..64), then go to PAD.
- PAD state (exactly 1 cycle, data_in_ready=0):
  - p<=55: write 0x80 at byte p, zeros in bytes p+1..55, bit_len in bytes 56..63. data_out_last=1, pending=0.
  - 56<=p<=63: write 0x80 at byte p, zeros in bytes p+1..63. data_out_last=0, pending=SECOND_LEN.
  - p==64: block is the data only. data_out_last=0, pending=SECOND_PAD.
  - In every case: data_out_valid=1 next cycle, go to EMIT.
- EMIT state:
  - data_in_ready=0. data_out and data_out_last stay stable while valid && !ready.
  - On handshake with pending=SECOND_LEN: next data_out = bytes 0..55 zero, bytes 56..63 = bit_len; last=1; valid stays 1; pending=0.
  - On handshake with pending=SECOND_PAD: next data_out = 0x80 at byte 0, zeros in bytes 1..55, bytes 56..63 = bit_len; last=1; valid stays 1; pending=0.
  - On handshake with pending=0: valid=0, go to FILL. If the block had last=1, clear bit_len and word_idx.
- Latency:
  - Non-last full block: data_out_valid rises 1 cycle after the 16th word is accepted.
  - Final block: data_out_valid rises 2 cycles after the last word is accepted (PAD, then EMIT).
  - Back-to-back second block: valid is asserted the cycle after the first block's handshake, with no bubble.
- The bit length field is big-endian; its MSB is data_out[63].
- No input is accepted while a block is outstanding. This is a single-block buffer.

Test Plan:
1. "abc": one word 0x61626300, bytes=3, last → one block: word0=0x61626380, words1..14=0, word15=0x00000018, last=1. Downstream digest = ba7816bf...f20015ad.
2. Empty message: word with bytes=0, last → one block: word0=0x80000000, all other words 0, length=0, last=1.
3. 56-byte message (14 words, last bytes=4) → block1: data, word14=0x80000000, word15=0, last=0; block2: all zero except word15=0x000001C0, last=1.
4. 64-byte message (16 words, last on word 15) → block1: data only, last=0; block2: word0=0x80000000, word15=0x00000200, last=1.
5. Backpressure: hold data_out_ready=0 for 10 cycles on each block of test 4 → valid stays high, data_out stable, data_in_ready=0 throughout, blocks unchanged.
6. Reset: assert sync_rst after 7 words, then send "abc" → output identical to test 1. Repeat with nrst pulsed asynchronously mid-EMIT: valid drops immediately.

Source files
------------

// File: rtl/hash_message_build.sv
`default_nettype none
// ============================================================================
// Module   : hash_message_build
// Packs 32-bit message words into SHA-256 padded 512-bit blocks.
// Revision : 1.0 - initial release
// ============================================================================
module hash_message_build #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [31:0]  data_in,
  input  logic [2:0]   data_in_bytes,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready
);

  localparam logic [1:0] c_fill      = 2'd0;
  localparam logic [1:0] c_pad       = 2'd1;
  localparam logic [1:0] c_emit      = 2'd2;
  localparam logic [1:0] c_pend_none = 2'd0;
  localparam logic [1:0] c_pend_len  = 2'd1;
  localparam logic [1:0] c_pend_pad  = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_word_idx;
  logic [LEN_W-1:0] r_bit_len;
  logic [1:0]       r_pending;
  logic [6:0]       r_pad_pos;
  logic [31:0]      r_buf [16];
  logic [511:0]     r_data_out;
  logic             r_last;
  logic             r_valid;

  logic [2:0]       w_bytes;
  logic [31:0]      w_masked;
  logic [LEN_W-1:0] w_len_add;
  logic [63:0]      w_len64;
  logic             w_accept;
  logic [511:0]     w_flat;
  logic [511:0]     w_full_block;
  logic [511:0]     w_pad_block;

  assign data_in_ready  = nrst && !sync_rst && en && (r_state == c_fill);
  assign data_out       = r_data_out;
  assign data_out_last  = r_last;
  assign data_out_valid = r_valid;

  assign w_accept  = data_in_valid && data_in_ready;
  assign w_bytes   = (data_in_bytes > 3'd4) ? 3'd4 : data_in_bytes;
  assign w_len_add = LEN_W'(data_in_last ? {w_bytes, 3'b000} : 6'd32);
  assign w_len64   = 64'(r_bit_len);

  always_comb begin
    case (w_bytes)
      3'd0:    w_masked = 32'h0;
      3'd1:    w_masked = {data_in[31:24], 24'h0};
      3'd2:    w_masked = {data_in[31:16], 16'h0};
      3'd3:    w_masked = {data_in[31:8], 8'h0};
      default: w_masked = data_in;
    endcase
  end

  always_comb begin
    w_flat = '0;
    for (int i = 0; i < 16; i++) begin
      w_flat[511-32*i -: 32] = r_buf[i];
    end
  end

  // The 16th word is still on the input bus when the full block is captured.
  assign w_full_block = {w_flat[511:32], data_in};

  always_comb begin
    w_pad_block = '0;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) < r_pad_pos) begin
        w_pad_block[511-8*b -: 8] = w_flat[511-8*b -: 8];
      end else if (7'(b) == r_pad_pos) begin
        w_pad_block[511-8*b -: 8] = 8'h80;
      end
    end
    if (r_pad_pos <= 7'd55) begin
      w_pad_block[63:0] = w_len64;
    end
  end

  // Buffer contents need no reset: bytes beyond the pad position are overwritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_word_idx] <= data_in_last ? w_masked : data_in;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= c_fill;
      r_word_idx <= '0;
      r_bit_len  <= '0;
      r_pending  <= c_pend_none;
      r_pad_pos  <= '0;
      r_data_out <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
    end else if (sync_rst) begin
      r_state    <= c_fill;
      r_word_idx <= '0;
      r_bit_len  <= '0;
      r_pending  <= c_pend_none;
      r_pad_pos  <= '0;
      r_data_out <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
    end else if (en) begin
      case (r_state)
        c_fill: begin
          if (w_accept) begin
            r_bit_len <= r_bit_len + w_len_add;
            if (data_in_last) begin
              r_pad_pos <= {1'b0, r_word_idx, 2'b00} + 7'(w_bytes);
              r_state   <= c_pad;
            end else if (r_word_idx == 4'd15) begin
              r_data_out <= w_full_block;
              r_last     <= 1'b0;
              r_valid    <= 1'b1;
              r_word_idx <= '0;
              r_state    <= c_emit;
            end else begin
              r_word_idx <= r_word_idx + 4'd1;
            end
          end
        end
        c_pad: begin
          r_data_out <= w_pad_block;
          r_valid    <= 1'b1;
          r_state    <= c_emit;
          if (r_pad_pos <= 7'd55) begin
            r_last    <= 1'b1;
            r_pending <= c_pend_none;
          end else if (r_pad_pos == 7'd64) begin
            r_last    <= 1'b0;
            r_pending <= c_pend_pad;
          end else begin
            r_last    <= 1'b0;
            r_pending <= c_pend_len;
          end
        end
        c_emit: begin
          if (data_out_ready) begin
            case (r_pending)
              c_pend_len: begin
                r_data_out <= {448'h0, w_len64};
                r_last     <= 1'b1;
                r_pending  <= c_pend_none;
              end
              c_pend_pad: begin
                r_data_out <= {8'h80, 440'h0, w_len64};
                r_last     <= 1'b1;
                r_pending  <= c_pend_none;
              end
              default: begin
                r_valid <= 1'b0;
                r_state <= c_fill;
                if (r_last) begin
                  r_bit_len  <= '0;
                  r_word_idx <= '0;
                end
              end
            endcase
          end
        end
        default: r_state <= c_fill;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_message_build.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_message_build
// Directed self-checking bench for hash_message_build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_message_build;

  logic         clk = 1'b0;
  logic         nrst;
  logic         en;
  logic         sync_rst;
  logic [31:0]  data_in;
  logic [2:0]   data_in_bytes;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp1;
  logic [511:0] exp2;

  always #5 clk = ~clk;

  hash_message_build #(.LEN_W(64)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_bytes  (data_in_bytes),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l);
    int n;
    @(negedge clk);
    data_in       = d;
    data_in_bytes = b;
    data_in_last  = l;
    data_in_valid = 1'b1;
    n = 0;
    while (!data_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", 512'(data_in_ready), 512'(1));
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  task automatic recv_block(input string tag, input logic [511:0] expv, input logic exp_last,
                            input int hold, input int exp_wait);
    int n;
    @(negedge clk);
    n = 0;
    while (!data_out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, 512'(data_out_valid), 512'(1));
    check({tag, "_latency"}, 512'(n), 512'(exp_wait));
    check({tag, "_data"}, data_out, expv);
    check({tag, "_last"}, 512'(data_out_last), 512'(exp_last));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 512'(data_out_valid), 512'(1));
      check({tag, "_hold_data"}, data_out, expv);
      check({tag, "_hold_last"}, 512'(data_out_last), 512'(exp_last));
      check({tag, "_hold_in_ready"}, 512'(data_in_ready), 512'(0));
    end
    data_out_ready = 1'b1;
    @(posedge clk);
    #1 data_out_ready = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
    data_in = '0; data_in_bytes = '0; data_in_last = 1'b0; data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 512'(data_out_valid), 512'(0));
    check("rst_last", 512'(data_out_last), 512'(0));
    check("rst_data", data_out, 512'(0));
    check("rst_in_ready", 512'(data_in_ready), 512'(0));
    nrst = 1'b1;
    @(negedge clk);
    check("fill_in_ready", 512'(data_in_ready), 512'(1));

    // "abc"
    exp1 = '0; exp1[511:480] = 32'h61626380; exp1[31:0] = 32'h18;
    send_word(32'h61626300, 3'd3, 1'b1);
    recv_block("abc", exp1, 1'b1, 0, 1);

    // empty message
    exp1 = '0; exp1[511:480] = 32'h80000000;
    send_word(32'hFFFFFFFF, 3'd0, 1'b1);
    recv_block("empty", exp1, 1'b1, 0, 1);

    // byte count above 4 is treated as 4
    exp1 = '0; exp1[511:480] = 32'h01020304; exp1[479:448] = 32'h80000000; exp1[31:0] = 32'h20;
    send_word(32'h01020304, 3'd7, 1'b1);
    recv_block("clamp", exp1, 1'b1, 0, 1);

    // 56-byte message: length spills into a second block
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 14; i++) exp1[511-32*i -: 32] = 32'hA0000000 + 32'(i);
    exp1[63:32] = 32'h80000000;
    exp2[31:0] = 32'h1C0;
    for (int i = 0; i < 14; i++) send_word(32'hA0000000 + 32'(i), 3'd4, i == 13);
    recv_block("m56_b1", exp1, 1'b0, 0, 1);
    recv_block("m56_b2", exp2, 1'b1, 0, 0);

    // 64-byte message: padding byte and length in a second block
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 16; i++) exp1[511-32*i -: 32] = 32'hB0000000 + 32'(i);
    exp2[511:480] = 32'h80000000; exp2[31:0] = 32'h200;
    for (int i = 0; i < 16; i++) send_word(32'hB0000000 + 32'(i), 3'd4, i == 15);
    recv_block("m64_b1", exp1, 1'b0, 0, 1);
    recv_block("m64_b2", exp2, 1'b1, 0, 0);

    // 64-byte message again under backpressure
    for (int i = 0; i < 16; i++) send_word(32'hB0000000 + 32'(i), 3'd4, i == 15);
    recv_block("bp_b1", exp1, 1'b0, 10, 1);
    recv_block("bp_b2", exp2, 1'b1, 10, 0);

    // 66-byte message: full non-last block then a short final word
    exp1 = '0; exp2 = '0;
    for (int i = 0; i < 16; i++) exp1[511-32*i -: 32] = 32'hC0000000 + 32'(i);
    exp2[511:480] = 32'hDEAD8000; exp2[31:0] = 32'h210;
    for (int i = 0; i < 16; i++) send_word(32'hC0000000 + 32'(i), 3'd4, 1'b0);
    recv_block("m66_b1", exp1, 1'b0, 0, 0);
    send_word(32'hDEADBEEF, 3'd2, 1'b1);
    recv_block("m66_b2", exp2, 1'b1, 0, 1);

    // enable low freezes an outstanding block
    exp1 = '0; exp1[511:480] = 32'h61626380; exp1[31:0] = 32'h18;
    send_word(32'h61626300, 3'd3, 1'b1);
    repeat (2) @(negedge clk);
    en = 1'b0; data_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("en_valid", 512'(data_out_valid), 512'(1));
    check("en_data", data_out, exp1);
    check("en_in_ready", 512'(data_in_ready), 512'(0));
    en = 1'b1; data_out_ready = 1'b0;
    recv_block("en_blk", exp1, 1'b1, 0, 0);

    // synchronous reset mid-message discards the partial message
    for (int i = 0; i < 7; i++) send_word(32'hE0000000 + 32'(i), 3'd4, 1'b0);
    @(negedge clk);
    sync_rst = 1'b1;
    @(negedge clk);
    check("srst_in_ready", 512'(data_in_ready), 512'(0));
    check("srst_valid", 512'(data_out_valid), 512'(0));
    sync_rst = 1'b0;
    send_word(32'h61626300, 3'd3, 1'b1);
    recv_block("srst_abc", exp1, 1'b1, 0, 1);

    // asynchronous reset while a block is being emitted
    send_word(32'h61626300, 3'd3, 1'b1);
    repeat (2) @(negedge clk);
    check("arst_pre_valid", 512'(data_out_valid), 512'(1));
    #2 nrst = 1'b0;
    #1;
    check("arst_valid", 512'(data_out_valid), 512'(0));
    check("arst_data", data_out, 512'(0));
    @(negedge clk);
    nrst = 1'b1;
    send_word(32'h61626300, 3'd3, 1'b1);
    recv_block("arst_abc", exp1, 1'b1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
